// File: rtl/mcucr_seq_guard.sv
// mcucr_seq_guard: protected-sequence guard for the MCUCR IO register.
// It snoops IO writes to MCUCR and enforces the two timed sequences:
// IVCE -> IVSEL (interrupts blocked while the window is open) and
// BODSE -> BODS (BODS self-expires after a fixed hold time).
// It also holds the unprotected PUD bit and provides the register read-back.
// Optional build macro: MCUCR_IVSEL_LOCK_EN adds ivsel_lock_i. While that
// input is high, a completing IVSEL write closes the window but leaves IVSEL
// unchanged.
module mcucr_seq_guard #(
    parameter logic [5:0] MCUCR_Address = 6'h35,
    parameter int         SEQ_WINDOW    = 4,
    parameter int         BODS_HOLD     = 3
) (
    input  logic       ireset,
    input  logic       cp2,
    input  logic [5:0] IO_Addr,
    input  logic [7:0] dbus_in,
    input  logic       iowe,
    input  logic       iore,
`ifdef MCUCR_IVSEL_LOCK_EN
    input  logic       ivsel_lock_i,
`endif
    output logic [7:0] dbus_out,
    output logic       out_en,
    output logic       ivsel_o,
    output logic       ivce_o,
    output logic       irq_block_o,
    output logic       bods_o,
    output logic       bodse_o,
    output logic       pud_o
);

    localparam int BSE_W  = (SEQ_WINDOW > 1) ? $clog2(SEQ_WINDOW + 1) : 1;
    localparam int HOLD_W = (BODS_HOLD > 1) ? $clog2(BODS_HOLD + 1) : 1;

    localparam logic [2:0]        IV_LOAD   = 3'(SEQ_WINDOW);
    localparam logic [BSE_W-1:0]  BSE_LOAD  = BSE_W'(SEQ_WINDOW);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(BODS_HOLD);

    logic [2:0]        ivcnt, ivcnt_nxt;
    logic              ivsel, ivsel_nxt;
    logic [BSE_W-1:0]  bsecnt, bsecnt_nxt;
    logic [HOLD_W-1:0] bodscnt, bodscnt_nxt;
    logic              pud, pud_nxt;

    logic wr;
    logic ivsel_lock;
    logic bods_arm;
    logic bods_complete;
    logic unused_bits;

    // Bits 7, 3 and 2 of the write data have no storage behind them.
    assign unused_bits = ^{dbus_in[7], dbus_in[3:2]};

`ifdef MCUCR_IVSEL_LOCK_EN
    assign ivsel_lock = ivsel_lock_i;
`else
    assign ivsel_lock = 1'b0;
`endif

    assign wr            = (IO_Addr == MCUCR_Address) && iowe;
    assign bods_arm      = wr && dbus_in[6] && dbus_in[5];
    assign bods_complete = wr && dbus_in[6] && !dbus_in[5] && (bsecnt != '0);

    // Next-state logic for the IVCE window and the IVSEL bit. An arming
    // write always (re)starts the window; a write with IVCE clear inside
    // the window completes it, and a write outside the window does nothing.
    always_comb begin
        ivcnt_nxt = ivcnt;
        ivsel_nxt = ivsel;
        if (wr && dbus_in[0]) begin
            ivcnt_nxt = IV_LOAD;
        end else if (wr && (ivcnt != 3'd0)) begin
            ivcnt_nxt = 3'd0;
            if (!ivsel_lock) begin
                ivsel_nxt = dbus_in[1];
            end
        end else if (ivcnt != 3'd0) begin
            ivcnt_nxt = ivcnt - 3'd1;
        end
    end

    // Next-state logic for the BODSE window and the BODS hold counter.
    // Writes that neither arm nor complete leave the window running.
    always_comb begin
        bsecnt_nxt  = bsecnt;
        bodscnt_nxt = bodscnt;
        if (bods_arm) begin
            bsecnt_nxt = BSE_LOAD;
        end else if (bods_complete) begin
            bsecnt_nxt = '0;
        end else if (bsecnt != '0) begin
            bsecnt_nxt = bsecnt - 1'b1;
        end
        if (bods_complete) begin
            bodscnt_nxt = HOLD_LOAD;
        end else if (bodscnt != '0) begin
            bodscnt_nxt = bodscnt - 1'b1;
        end
    end

    // PUD is unprotected and simply follows every MCUCR write.
    always_comb begin
        pud_nxt = pud;
        if (wr) begin
            pud_nxt = dbus_in[4];
        end
    end

    // State registers; reset clears every window and hold immediately.
    always_ff @(posedge cp2 or negedge ireset) begin
        if (!ireset) begin
            ivcnt   <= 3'd0;
            ivsel   <= 1'b0;
            bsecnt  <= '0;
            bodscnt <= '0;
            pud     <= 1'b0;
        end else begin
            ivcnt   <= ivcnt_nxt;
            ivsel   <= ivsel_nxt;
            bsecnt  <= bsecnt_nxt;
            bodscnt <= bodscnt_nxt;
            pud     <= pud_nxt;
        end
    end

    assign ivce_o      = (ivcnt != 3'd0);
    assign irq_block_o = ivce_o;
    assign ivsel_o     = ivsel;
    assign bodse_o     = (bsecnt != '0);
    assign bods_o      = (bodscnt != '0);
    assign pud_o       = pud;

    assign out_en   = (IO_Addr == MCUCR_Address) && iore;
    assign dbus_out = {1'b0, bods_o, bodse_o, pud_o, 2'b00, ivsel_o, ivce_o};

endmodule

// File: tb/tb_mcucr_seq_guard.sv
// tb_mcucr_seq_guard: directed and randomized checks of mcucr_seq_guard
// against a deadline-based reference model of the MCUCR protected sequences.
module tb_mcucr_seq_guard;

    localparam logic [5:0] ADDR = 6'h35;
    localparam int         WIN  = 4;
    localparam int         HOLD = 3;

    logic       cp2 = 1'b0;
    logic       ireset;
    logic [5:0] io_addr;
    logic [7:0] dbus_in;
    logic       iowe;
    logic       iore;
    logic [7:0] dbus_out;
    logic       out_en;
    logic       ivsel_o;
    logic       ivce_o;
    logic       irq_block_o;
    logic       bods_o;
    logic       bodse_o;
    logic       pud_o;
`ifdef MCUCR_IVSEL_LOCK_EN
    logic       ivsel_lock = 1'b0;
`endif

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: absolute edge numbers for window deadlines and hold end
    int   iv_deadline;
    int   bse_deadline;
    int   bods_until;
    logic m_ivsel;
    logic m_pud;

    mcucr_seq_guard dut (
        .ireset      (ireset),
        .cp2         (cp2),
        .IO_Addr     (io_addr),
        .dbus_in     (dbus_in),
        .iowe        (iowe),
        .iore        (iore),
`ifdef MCUCR_IVSEL_LOCK_EN
        .ivsel_lock_i(ivsel_lock),
`endif
        .dbus_out    (dbus_out),
        .out_en      (out_en),
        .ivsel_o     (ivsel_o),
        .ivce_o      (ivce_o),
        .irq_block_o (irq_block_o),
        .bods_o      (bods_o),
        .bodse_o     (bodse_o),
        .pud_o       (pud_o)
    );

    // Free-running core clock
    always #5 cp2 = ~cp2;

    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        iv_deadline  = -100;
        bse_deadline = -100;
        bods_until   = -100;
        m_ivsel      = 1'b0;
        m_pud        = 1'b0;
    endtask

    // Apply the MCUCR rules for the edge numbered cyc using the current inputs
    task automatic modelEdge();
        logic wr;
        logic lk;
        int   n;
        n  = cyc;
        lk = 1'b0;
`ifdef MCUCR_IVSEL_LOCK_EN
        lk = ivsel_lock;
`endif
        wr = (io_addr == ADDR) && iowe;
        if (wr) begin
            if (dbus_in[0]) begin
                iv_deadline = n + WIN;
            end else if (n <= iv_deadline) begin
                if (!lk) m_ivsel = dbus_in[1];
                iv_deadline = -100;
            end
            if (dbus_in[6] && dbus_in[5]) begin
                bse_deadline = n + WIN;
            end else if (dbus_in[6] && n <= bse_deadline) begin
                bods_until   = n + HOLD - 1;
                bse_deadline = -100;
            end
            m_pud = dbus_in[4];
        end
    endtask

    // Compare every DUT output with the model's view after edge cyc
    task automatic checkAll(input string tag);
        logic       e_ive;
        logic       e_bse;
        logic       e_bods;
        logic [7:0] e_dbus;
        e_ive  = (cyc + 1 <= iv_deadline);
        e_bse  = (cyc + 1 <= bse_deadline);
        e_bods = (cyc <= bods_until);
        e_dbus = {1'b0, e_bods, e_bse, m_pud, 2'b00, m_ivsel, e_ive};
        checkOutput({tag, ":ivce"},   {7'd0, ivce_o},      {7'd0, e_ive});
        checkOutput({tag, ":irqblk"}, {7'd0, irq_block_o}, {7'd0, e_ive});
        checkOutput({tag, ":ivsel"},  {7'd0, ivsel_o},     {7'd0, m_ivsel});
        checkOutput({tag, ":bodse"},  {7'd0, bodse_o},     {7'd0, e_bse});
        checkOutput({tag, ":bods"},   {7'd0, bods_o},      {7'd0, e_bods});
        checkOutput({tag, ":pud"},    {7'd0, pud_o},       {7'd0, m_pud});
        checkOutput({tag, ":out_en"}, {7'd0, out_en},      {7'd0, (io_addr == ADDR) && iore});
        if (iore && io_addr == ADDR) begin
            checkOutput({tag, ":dbus"}, dbus_out, e_dbus);
        end
    endtask

    // Drive one bus cycle, advance the model on the edge and check after it
    task automatic applyStimulus(input string tag, input logic [5:0] a, input logic [7:0] d,
                                 input logic we, input logic re);
        io_addr = a;
        dbus_in = d;
        iowe    = we;
        iore    = re;
        @(posedge cp2);
        cyc++;
        modelEdge();
        #1;
        checkAll(tag);
    endtask

    task automatic mcucrWrite(input string tag, input logic [7:0] d);
        applyStimulus(tag, ADDR, d, 1'b1, 1'b0);
    endtask

    task automatic idleRead(input string tag);
        applyStimulus(tag, ADDR, 8'h00, 1'b0, 1'b1);
    endtask

    initial begin
        logic [7:0] pats [10];
        pats = '{8'h01, 8'h02, 8'h00, 8'h60, 8'h40, 8'h20, 8'h61, 8'h42, 8'h10, 8'h03};

        // Reset and read-back of the cleared register
        ireset  = 1'b0;
        io_addr = ADDR;
        dbus_in = 8'h00;
        iowe    = 1'b0;
        iore    = 1'b1;
        modelReset();
        repeat (2) @(posedge cp2);
        @(negedge cp2);
        ireset = 1'b1;
        #1;
        checkAll("reset");
        checkOutput("reset_dbus", dbus_out, 8'h00);

        // IVSEL sequence completed two cycles after arming
        mcucrWrite("iv_arm", 8'h01);
        idleRead("iv_wait");
        mcucrWrite("iv_done", 8'h02);
        idleRead("iv_read");
        checkOutput("iv_readback", dbus_out, 8'h02);

        // Clear IVSEL, then let a window expire before the completing write
        mcucrWrite("iv_arm2", 8'h01);
        mcucrWrite("iv_clr", 8'h00);
        mcucrWrite("iv_arm3", 8'h01);
        repeat (4) idleRead("iv_expire");
        mcucrWrite("iv_late", 8'h02);
        checkOutput("iv_late_ivsel", {7'd0, ivsel_o}, 8'h00);

        // BODS sequence and its hold, then completion without arming
        mcucrWrite("bs_arm", 8'h60);
        mcucrWrite("bs_done", 8'h40);
        repeat (4) idleRead("bs_hold");
        mcucrWrite("bs_noarm", 8'h40);
        idleRead("bs_noarm_rd");

        // PUD follows writes; combined sequences in one pair of writes
        mcucrWrite("pud_set", 8'h10);
        mcucrWrite("pud_clr", 8'h00);
        mcucrWrite("both_arm", 8'h61);
        mcucrWrite("both_done", 8'h42);
        checkOutput("both_ivsel", {7'd0, ivsel_o}, 8'h01);
        repeat (4) idleRead("both_hold");

        // Asynchronous reset in the middle of an open window
        mcucrWrite("rst_arm", 8'h01);
        #3 ireset = 1'b0;
        #1;
        checkOutput("rst_ivce", {7'd0, ivce_o}, 8'h00);
        checkOutput("rst_irqblk", {7'd0, irq_block_o}, 8'h00);
        checkOutput("rst_ivsel", {7'd0, ivsel_o}, 8'h00);
        modelReset();
        @(posedge cp2);
        @(negedge cp2);
        ireset = 1'b1;

`ifdef MCUCR_IVSEL_LOCK_EN
        // Locked IVSEL: the window closes but the select bit stays put
        ivsel_lock = 1'b1;
        mcucrWrite("lk_arm", 8'h01);
        mcucrWrite("lk_done", 8'h02);
        checkOutput("lk_ivsel", {7'd0, ivsel_o}, 8'h00);
        checkOutput("lk_ivce", {7'd0, ivce_o}, 8'h00);
        ivsel_lock = 1'b0;
`endif

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            logic [5:0] a;
            logic [7:0] d;
            a = ($urandom_range(0, 9) == 0) ? 6'($urandom) : ADDR;
            d = ($urandom_range(0, 4) == 0) ? 8'($urandom) : pats[$urandom_range(0, 9)];
`ifdef MCUCR_IVSEL_LOCK_EN
            ivsel_lock = ($urandom_range(0, 3) == 0);
`endif
            applyStimulus("rand", a, d, $urandom_range(0, 2) != 0, $urandom_range(0, 1) != 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mcucr_seq_guard.md
Name: mcucr_seq_guard

Overview:
Timed-sequence enforcement stage for MCUCR, sitting between the AVR IO bus and the interrupt-vector and sleep/BOD logic. It snoops IO writes to the MCUCR address and applies the two ATmega328PB protected sequences:
- IVCE → IVSEL change, with interrupts blocked while the window is open.
- BODSE → BODS, with BODS auto-expiring.
It drives the effective IVSEL/BODS/PUD controls and provides their read-back.

Parameters:
MCUCR_Address, 6'h35, IO address of MCUCR
SEQ_WINDOW, 4, clock edges after arming during which the completing write is accepted
BODS_HOLD, 3, cycles BODS stays asserted after a valid BODS sequence

Ports:
ireset  input  1  reset, asynchronous, active-low
cp2  input  1  core clock, all state updates on rising edge
IO_Addr  input  6  IO address
dbus_in  input  8  IO write data
iowe  input  1  IO write strobe
iore  input  1  IO read strobe
dbus_out  output  8  read-back {1'b0, bods, bodse, pud, 2'b00, ivsel, ivce}
out_en  output  1  high when IO_Addr==MCUCR_Address && iore (combinational)
ivsel_o  output  1  effective interrupt-vector select
ivce_o  output  1  IVCE window open
irq_block_o  output  1  global interrupt block; equals ivce_o
bods_o  output  1  BOD disable request to sleep controller
bodse_o  output  1  BODSE window open
pud_o  output  1  pull-up disable

Behaviour:
- Reset state: all counters 0; all outputs 0, including ivsel_o, pud_o and dbus_out.
- wr = (IO_Addr==MCUCR_Address) && iowe, sampled on the cp2 rising edge. d = dbus_in.
- IVCE window:
  - 3-bit counter ivcnt; ivce_o = (ivcnt != 0).
  - On wr with d[0]=1: ivcnt <= SEQ_WINDOW; ivsel unchanged. This also restarts an already-open window.
  - On wr with d[0]=0 while ivcnt != 0: ivsel <= d[1], ivcnt <= 0.
  - On wr with d[0]=0 while ivcnt == 0: ivsel unchanged.
  - Otherwise, if ivcnt != 0: ivcnt decrements.
  - The completing write is accepted on any of the SEQ_WINDOW edges following the arming edge. After that, ivce_o falls and the sequence is dead.
- BODSE window:
  - Counter bsecnt; bodse_o = (bsecnt != 0).
  - On wr with d[6]=1 && d[5]=1: bsecnt <= SEQ_WINDOW; bods unchanged.
  - On wr with d[6]=1 && d[5]=0 while bsecnt != 0: bodscnt <= BODS_HOLD, bsecnt <= 0.
  - Any other MCUCR write while bsecnt != 0: bsecnt decrements normally; no abort.
  - Otherwise, bsecnt decrements toward 0.
- BODS hold:
  - bods_o = (bodscnt != 0).
  - bodscnt decrements each cycle, so bods_o is high for exactly BODS_HOLD cycles.
  - A new valid sequence during hold reloads bodscnt.
- PUD: pud <= d[4] on every wr, with no protection.
- Independence: IVCE and BODSE sequences are independent. A single write may arm or complete both.
- Bits 7, 3 and 2 are ignored on write and read back as 0.
- No read side effects.
- Reset asserted mid-window or mid-hold: immediate asynchronous clear of all state. A write in the same cycle as reset release is not required to be captured.

Optional Feature:
- Macro: MCUCR_IVSEL_LOCK_EN.
- When defined:
  - Adds input port ivsel_lock_i (1 bit, from boot-lock fuse logic).
  - While ivsel_lock_i=1, a completing IVSEL write still closes the IVCE window, but ivsel is not updated.
- When undefined: the port is absent and IVSEL updates exactly as above.

Test Plan:
- Reset release, then read MCUCR → out_en=1, dbus_out=8'h00, all outputs 0.
- Write 8'h01, then 8'h02 two cycles later → ivce_o/irq_block_o high for 2 cycles then low; ivsel_o=1; read-back 8'h02.
- Write 8'h01, idle 4 cycles, then write 8'h02 → ivce_o high exactly 4 cycles; ivsel_o stays 0.
- Write 8'h60, then 8'h40 on the next cycle → bodse_o high 1 cycle; bods_o high exactly 3 cycles then 0. Write 8'h40 with no arm → bods_o stays 0.
- Write 8'h10, then 8'h00 → pud_o 1 then 0 immediately. Write 8'h61, then 8'h42 → both sequences complete: ivsel_o=1 and bods_o pulses for 3 cycles.
- Write 8'h01, assert ireset low one cycle later → ivce_o, irq_block_o and ivcnt clear asynchronously. With MCUCR_IVSEL_LOCK_EN defined and lock=1: write 01 then 02 → ivsel_o stays 0 and the window closes.
